// File: rtl/fetch_ctrl_if.sv
// Fetch bus: ROM address/data, decode valid/ready handshake, redirect/halt control, fault status.
// master = fetch_ctrl, slave = ROM, decode and branch side.
interface fetch_ctrl_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output fault,
        output fault_pc
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC owner, 1-cycle ROM tracking, small output FIFO; first word 2 cycles after issue.
// Backpressure: issues only while FIFO occupancy plus in-flight word leaves room, so nothing overflows.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_BYTES  = 16384,
    parameter int          FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_ctrl_if.master bus
);
    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [31:0]     MAX_PC  = 32'(MEM_BYTES - 4);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             pending_q, pending_d;
    logic [31:0]      pending_pc_q, pending_pc_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [31:0]      data_q [FIFO_DEPTH];
    logic [31:0]      data_d [FIFO_DEPTH];
    logic [31:0]      pcs_q  [FIFO_DEPTH];
    logic [31:0]      pcs_d  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             pop, push, issue_ok, issue;
    logic [CNT_W:0]   occ;

    function automatic logic legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc <= MAX_PC);
    endfunction

    always_comb begin
        pop      = (count_q != '0) && bus.inst_ready;
        push     = pending_q;
        // Slots that will be committed after this edge if nothing new is issued.
        occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q} - {{CNT_W{1'b0}}, pop};
        issue_ok = (state_q != FAULT) && !bus.halt && !bus.redirect_valid && (occ < DEPTH_C);
        issue    = issue_ok && legal(fetch_pc_q);

        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_d    = issue;
        pending_pc_d = pending_pc_q;
        fault_pc_d   = fault_pc_q;
        data_d       = data_q;
        pcs_d        = pcs_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

        if (issue) begin
            pending_pc_d = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + 32'd4;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            data_d[wr_ptr_q] = bus.mem_rdata;
            pcs_d[wr_ptr_q]  = pending_pc_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (bus.redirect_valid) begin
            // Flush drops the capture and the in-flight word; the head pop this cycle is already consumed.
            fetch_pc_d = bus.redirect_pc;
            pending_d  = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            if (legal(bus.redirect_pc) || (state_q != FAULT)) begin
                state_d = bus.halt ? HALTED : RUN;
            end else begin
                fault_pc_d = bus.redirect_pc;
            end
        end else if (issue_ok && !legal(fetch_pc_q)) begin
            state_d    = FAULT;
            fault_pc_d = fetch_pc_q;
        end else if (state_q != FAULT) begin
            state_d = bus.halt ? HALTED : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            fault_pc_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            fault_pc_q   <= fault_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            pcs_q        <= pcs_d;
        end
    end

    assign bus.mem_addr   = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_data  = data_q[rd_ptr_q];
    assign bus.inst_pc    = pcs_q[rd_ptr_q];
    assign bus.fault      = (state_q == FAULT);
    assign bus.fault_pc   = fault_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: registered ROM model plus a queue of expected PCs checked at every accepted handshake.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (16384),
        .FIFO_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) bus.mem_rdata <= rom_word(bus.mem_addr);

    // Advance one cycle: scoreboard any handshake at the falling edge, then return just after the rising edge.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        if (rst_n && bus.inst_valid && bus.inst_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL accept_extra: got pc %h, required no instruction", bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                if (bus.inst_pc !== e || bus.inst_data !== rom_word(e)) begin
                    n_bad++;
                    $display("FAIL accept_order: got pc %h data %h, required pc %h data %h",
                             bus.inst_pc, bus.inst_data, e, rom_word(e));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic do_reset(input logic rdy);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        bus.inst_ready     = rdy;
        step();
        step();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        rst_n = 1'b0;
        step();
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", bus.inst_valid); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h, required 0", bus.mem_addr); end
        n_cmp++; if (bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0) begin n_bad++; $display("FAIL rst_head: got data %h pc %h, required 0 0", bus.inst_data, bus.inst_pc); end
        n_cmp++; if (bus.fault !== 1'b0 || bus.fault_pc !== 32'h0) begin n_bad++; $display("FAIL rst_fault: got %b %h, required 0 0", bus.fault, bus.fault_pc); end
    endtask

    task automatic test_first_fetch();
        do_reset(1'b1);
        push_seq(32'h0, 16);
        step();
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 32'h4) begin n_bad++; $display("FAIL first_e1: got valid %b addr %h, required 0 4", bus.inst_valid, bus.mem_addr); end
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin n_bad++; $display("FAIL first_e2: got valid %b pc %h, required 1 0", bus.inst_valid, bus.inst_pc); end
        for (int i = 1; i < 4; i++) begin
            step();
            n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_b2b: got valid %b pc %h, required 1 %h", bus.inst_valid, bus.inst_pc, 32'(4 * i)); end
        end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        push_seq(32'h0, 16);
        repeat (6) step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head: got valid %b pc %h, required 1 0", bus.inst_valid, bus.inst_pc); end
        n_cmp++; if (bus.mem_addr !== 32'h8) begin n_bad++; $display("FAIL bp_addr: got %h, required 8", bus.mem_addr); end
        bus.inst_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_resume: got valid %b pc %h, required 1 %h", bus.inst_valid, bus.inst_pc, 32'(4 * i)); end
        end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        push_seq(32'h0, 3);
        repeat (4) step();
        n_cmp++; if (bus.inst_pc !== 32'h8) begin n_bad++; $display("FAIL redir_pre: got pc %h, required 8", bus.inst_pc); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        push_seq(32'h100, 8);
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 32'h100) begin n_bad++; $display("FAIL redir_flush: got valid %b addr %h, required 0 100", bus.inst_valid, bus.mem_addr); end
        step();
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL redir_t2: got valid %b, required 0", bus.inst_valid); end
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100) begin n_bad++; $display("FAIL redir_t3: got valid %b pc %h, required 1 100", bus.inst_valid, bus.inst_pc); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_fault();
        do_reset(1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.mem_addr !== 32'h102 || bus.fault !== 1'b0) begin n_bad++; $display("FAIL fault_pre: got addr %h fault %b, required 102 0", bus.mem_addr, bus.fault); end
        step();
        n_cmp++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h102) begin n_bad++; $display("FAIL fault_entry: got %b %h, required 1 102", bus.fault, bus.fault_pc); end
        repeat (3) begin
            step();
            n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL fault_quiet: got valid %b, required 0", bus.inst_valid); end
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h5000;
        step();
        n_cmp++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h5000) begin n_bad++; $display("FAIL fault_update: got %b %h, required 1 5000", bus.fault, bus.fault_pc); end
        bus.redirect_pc = 32'h40;
        push_seq(32'h40, 8);
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b, required 0", bus.fault); end
        step();
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40) begin n_bad++; $display("FAIL fault_recover: got valid %b pc %h, required 1 40", bus.inst_valid, bus.inst_pc); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_runoff();
        do_reset(1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd16376;
        push_seq(32'd16376, 2);
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.mem_addr !== 32'd16376) begin n_bad++; $display("FAIL runoff_addr: got %h, required %h", bus.mem_addr, 32'd16376); end
        step();
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd16376) begin n_bad++; $display("FAIL runoff_first: got valid %b pc %h, required 1 %h", bus.inst_valid, bus.inst_pc, 32'd16376); end
        step();
        n_cmp++; if (bus.inst_pc !== 32'd16380) begin n_bad++; $display("FAIL runoff_last: got pc %h, required %h", bus.inst_pc, 32'd16380); end
        n_cmp++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'd16384) begin n_bad++; $display("FAIL runoff_fault: got %b %h, required 1 %h", bus.fault, bus.fault_pc, 32'd16384); end
        step();
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL runoff_stop: got valid %b, required 0", bus.inst_valid); end
        step();
        step();
        n_cmp++; if (exp_q.size() != 0 || bus.fault !== 1'b1) begin n_bad++; $display("FAIL runoff_drain: got %0d left fault %b, required 0 left fault 1", exp_q.size(), bus.fault); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_halt_and_reset();
        do_reset(1'b1);
        push_seq(32'h0, 24);
        repeat (4) step();
        n_cmp++; if (bus.mem_addr !== 32'h10 || bus.inst_pc !== 32'h8) begin n_bad++; $display("FAIL halt_pre: got addr %h pc %h, required 10 8", bus.mem_addr, bus.inst_pc); end
        bus.halt = 1'b1;
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hc || bus.mem_addr !== 32'h10) begin n_bad++; $display("FAIL halt_drain: got valid %b pc %h addr %h, required 1 c 10", bus.inst_valid, bus.inst_pc, bus.mem_addr); end
        repeat (3) begin
            step();
            n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 32'h10) begin n_bad++; $display("FAIL halt_hold: got valid %b addr %h, required 0 10", bus.inst_valid, bus.mem_addr); end
        end
        bus.halt = 1'b0;
        step();
        n_cmp++; if (bus.mem_addr !== 32'h14) begin n_bad++; $display("FAIL halt_resume_addr: got %h, required 14", bus.mem_addr); end
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h10) begin n_bad++; $display("FAIL halt_resume: got valid %b pc %h, required 1 10", bus.inst_valid, bus.inst_pc); end
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 32'h0 || bus.fault !== 1'b0) begin n_bad++; $display("FAIL midrst: got valid %b addr %h fault %b, required 0 0 0", bus.inst_valid, bus.mem_addr, bus.fault); end
        exp_q.delete();
        step();
        rst_n = 1'b1;
        push_seq(32'h0, 8);
        step();
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_e1: got valid %b, required 0", bus.inst_valid); end
        step();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin n_bad++; $display("FAIL midrst_refetch: got valid %b pc %h, required 1 0", bus.inst_valid, bus.inst_pc); end
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_fault();
        test_runoff();
        test_halt_and_reset();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
